gtfraw_vnc_lat_mon_core: RTL and testbench

Latency-monitor datapath that feeds the latency-monitor AXI-Lite register block. It timestamps TX and RX marker events against a free-running timer and pairs each RX event with the oldest outstanding TX event. Each pair goes into a time-pair FIFO that software drains through the pop interface. Per-pair delta statistics (accumulate, count, max, min) run until a programmed packet count is reached. All activity is in the AXI clock domain; tx_evt and rx_evt arrive already synchronised.

---
 rtl/gtfraw_vnc_lat_mon_pkg.sv | 14 +
 rtl/gtfraw_vnc_lat_mon_fifo.sv | 75 +++++++
 rtl/gtfraw_vnc_lat_mon_core.sv | 164 ++++++++++++++++
 tb/tb_gtfraw_vnc_lat_mon_core.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gtfraw_vnc_lat_mon_pkg.sv
// Shared types and constants for the latency-monitor datapath.
package gtfraw_vnc_lat_mon_pkg;

    localparam int unsigned LM_TIMER_WIDTH       = 16;
    // Edges from an accepted rx_evt to its statistics update: pair write, then stats.
    localparam int unsigned LM_PIPE_DEPTH        = 2;
    localparam bit          LM_ZERO_ON_EMPTY_POP = 1'b1;

    typedef struct packed {
        logic [LM_TIMER_WIDTH-1:0] snd;
        logic [LM_TIMER_WIDTH-1:0] rcv;
    } time_pair_t;

endpackage

// File: rtl/gtfraw_vnc_lat_mon_fifo.sv
// Synchronous FIFO with registered read, occupancy count and flush.
module gtfraw_vnc_lat_mon_fifo
    import gtfraw_vnc_lat_mon_pkg::*;
#(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AW            = $clog2(DEPTH),
    parameter bit          ZERO_ON_EMPTY = LM_ZERO_ON_EMPTY_POP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [AW:0]      count,
    output logic             full
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_rd;
    logic             do_wr;

    assign full  = (count == FULL_CNT);
    assign do_rd = rd_en & (count != '0);
    // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
    assign do_wr = wr_en & (~full | do_rd);

    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_valid <= rd_en;
            if (rd_en && ZERO_ON_EMPTY) begin
                rd_data <= '0;
            end
        end else begin
            rd_valid <= rd_en;
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr    <= rptr + 1'b1;
                rd_data <= mem[rptr];
            end else if (rd_en && ZERO_ON_EMPTY) begin
                rd_data <= '0;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gtfraw_vnc_lat_mon_core.sv
// Latency monitor: timestamps tx/rx markers, pairs them FIFO-order, stores
// pairs for software and accumulates delta statistics.
module gtfraw_vnc_lat_mon_core
    import gtfraw_vnc_lat_mon_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH    = 16,
    parameter int unsigned RAM_DEPTH      = 4096,
    parameter int unsigned RAM_ADDR_WIDTH = 12,
    parameter int unsigned PEND_DEPTH     = 16,
    parameter int unsigned ADJ_FACTOR     = 0
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic                      tx_evt,
    input  logic                      rx_evt,
    input  logic                      lm_go,
    input  logic                      lm_clear,
    input  logic                      lm_pop,
    input  logic [31:0]               lm_lat_pkt_cnt,
    output logic                      lm_full,
    output logic [RAM_ADDR_WIDTH:0]   lm_datav,
    output logic [TIMER_WIDTH-1:0]    lm_snd_time,
    output logic [TIMER_WIDTH-1:0]    lm_rcv_time,
    output logic                      lm_time_rdy,
    output logic [31:0]               lm_delta_time_accu,
    output logic [31:0]               lm_delta_time_idx,
    output logic [TIMER_WIDTH-1:0]    lm_delta_time_max,
    output logic [TIMER_WIDTH-1:0]    lm_delta_time_min,
    output logic                      lm_delta_done_sync,
    output logic [TIMER_WIDTH-1:0]    lm_delta_adj_factor,
    output logic [15:0]               lm_err_cnt
);

    localparam logic [TIMER_WIDTH-1:0] ADJ     = TIMER_WIDTH'(ADJ_FACTOR);
    localparam int unsigned            PEND_AW = $clog2(PEND_DEPTH);

    logic [TIMER_WIDTH-1:0]   timer;
    logic                     tx_go;
    logic                     rx_go;
    logic                     pend_rd;
    logic                     pend_empty;
    logic                     pend_full;
    logic [PEND_AW:0]         pend_count;
    logic                     s1_valid;
    logic [TIMER_WIDTH-1:0]   snd_head;
    logic [TIMER_WIDTH-1:0]   s1_rcv;
    logic [TIMER_WIDTH-1:0]   raw_delta;
    logic [TIMER_WIDTH:0]     adj_diff;
    logic [TIMER_WIDTH-1:0]   adj_delta;
    logic                     s2_valid;
    logic [TIMER_WIDTH-1:0]   s2_adj;
    logic [2*TIMER_WIDTH-1:0] pair_rd;
    logic [32:0]              accu_sum;
    logic                     cnt_reached;
    logic                     stats_open;
    logic                     err_inc;

    assign tx_go      = tx_evt & lm_go & ~lm_clear;
    assign rx_go      = rx_evt & lm_go & ~lm_clear;
    assign pend_empty = (pend_count == '0);
    assign pend_rd    = rx_go & ~pend_empty;
    assign err_inc    = (rx_go & pend_empty) | (tx_go & pend_full & ~pend_rd);

    assign lm_delta_adj_factor = ADJ;
    assign lm_snd_time         = pair_rd[2*TIMER_WIDTH-1:TIMER_WIDTH];
    assign lm_rcv_time         = pair_rd[TIMER_WIDTH-1:0];

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    gtfraw_vnc_lat_mon_fifo #(
        .WIDTH         (TIMER_WIDTH),
        .DEPTH         (PEND_DEPTH),
        .AW            (PEND_AW),
        .ZERO_ON_EMPTY (LM_ZERO_ON_EMPTY_POP)
    ) u_pend (
        .clk      (axi_aclk),
        .rst_n    (axi_aresetn),
        .flush    (lm_clear),
        .wr_en    (tx_go),
        .wr_data  (timer),
        .rd_en    (pend_rd),
        .rd_data  (snd_head),
        .rd_valid (s1_valid),
        .count    (pend_count),
        .full     (pend_full)
    );

    // The pending queue's registered read lines up the send stamp with s1_rcv.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            s1_rcv <= '0;
        end else if (pend_rd) begin
            s1_rcv <= timer;
        end
    end

    always_comb begin
        raw_delta = s1_rcv - snd_head;
        adj_diff  = {1'b0, raw_delta} - {1'b0, ADJ};
        adj_delta = adj_diff[TIMER_WIDTH] ? '0 : adj_diff[TIMER_WIDTH-1:0];
    end

    gtfraw_vnc_lat_mon_fifo #(
        .WIDTH         (2*TIMER_WIDTH),
        .DEPTH         (RAM_DEPTH),
        .AW            (RAM_ADDR_WIDTH),
        .ZERO_ON_EMPTY (LM_ZERO_ON_EMPTY_POP)
    ) u_pair (
        .clk      (axi_aclk),
        .rst_n    (axi_aresetn),
        .flush    (lm_clear),
        .wr_en    (s1_valid),
        .wr_data  ({snd_head, s1_rcv}),
        .rd_en    (lm_pop),
        .rd_data  (pair_rd),
        .rd_valid (lm_time_rdy),
        .count    (lm_datav),
        .full     (lm_full)
    );

    assign accu_sum    = {1'b0, lm_delta_time_accu} + 33'(s2_adj);
    assign cnt_reached = (lm_lat_pkt_cnt != '0) && (lm_delta_time_idx >= lm_lat_pkt_cnt);
    // Stop accepting pairs as soon as the count is hit so back-to-back pairs cannot overshoot.
    assign stats_open  = ~lm_delta_done_sync & ~cnt_reached;

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn || lm_clear) begin
            s2_valid           <= 1'b0;
            s2_adj             <= '0;
            lm_delta_time_accu <= '0;
            lm_delta_time_idx  <= '0;
            lm_delta_time_max  <= '0;
            lm_delta_time_min  <= '1;
            lm_delta_done_sync <= 1'b0;
            lm_err_cnt         <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_adj   <= adj_delta;
            if (err_inc && (lm_err_cnt != '1)) begin
                lm_err_cnt <= lm_err_cnt + 1'b1;
            end
            if (s2_valid && stats_open) begin
                lm_delta_time_idx  <= lm_delta_time_idx + 1'b1;
                lm_delta_time_accu <= accu_sum[32] ? '1 : accu_sum[31:0];
                if (s2_adj > lm_delta_time_max) begin
                    lm_delta_time_max <= s2_adj;
                end
                if (s2_adj < lm_delta_time_min) begin
                    lm_delta_time_min <= s2_adj;
                end
            end
            if (cnt_reached) begin
                lm_delta_done_sync <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gtfraw_vnc_lat_mon_core.sv
// Self-checking bench for gtfraw_vnc_lat_mon_core with a pair scoreboard.
module tb_gtfraw_vnc_lat_mon_core;
    import gtfraw_vnc_lat_mon_pkg::*;

    localparam int RD = 4096;
    localparam int PD = 16;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic        tx_evt = 1'b0;
    logic        rx_evt = 1'b0;
    logic        lm_go = 1'b0;
    logic        lm_clear = 1'b0;
    logic        lm_pop = 1'b0;
    logic [31:0] lm_lat_pkt_cnt = '0;

    logic        lm_full, lm_time_rdy, lm_delta_done_sync;
    logic [12:0] lm_datav;
    logic [15:0] lm_snd_time, lm_rcv_time, lm_delta_time_max, lm_delta_time_min;
    logic [15:0] lm_delta_adj_factor, lm_err_cnt;
    logic [31:0] lm_delta_time_accu, lm_delta_time_idx;

    logic        a_full, a_time_rdy, a_done;
    logic [12:0] a_datav;
    logic [15:0] a_snd, a_rcv, a_max, a_min, a_adj, a_err;
    logic [31:0] a_accu, a_idx;

    gtfraw_vnc_lat_mon_core dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .tx_evt(tx_evt), .rx_evt(rx_evt),
        .lm_go(lm_go), .lm_clear(lm_clear), .lm_pop(lm_pop), .lm_lat_pkt_cnt(lm_lat_pkt_cnt),
        .lm_full(lm_full), .lm_datav(lm_datav), .lm_snd_time(lm_snd_time),
        .lm_rcv_time(lm_rcv_time), .lm_time_rdy(lm_time_rdy),
        .lm_delta_time_accu(lm_delta_time_accu), .lm_delta_time_idx(lm_delta_time_idx),
        .lm_delta_time_max(lm_delta_time_max), .lm_delta_time_min(lm_delta_time_min),
        .lm_delta_done_sync(lm_delta_done_sync), .lm_delta_adj_factor(lm_delta_adj_factor),
        .lm_err_cnt(lm_err_cnt)
    );

    gtfraw_vnc_lat_mon_core #(.ADJ_FACTOR(48)) dut_adj (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .tx_evt(tx_evt), .rx_evt(rx_evt),
        .lm_go(lm_go), .lm_clear(lm_clear), .lm_pop(lm_pop), .lm_lat_pkt_cnt(lm_lat_pkt_cnt),
        .lm_full(a_full), .lm_datav(a_datav), .lm_snd_time(a_snd), .lm_rcv_time(a_rcv),
        .lm_time_rdy(a_time_rdy), .lm_delta_time_accu(a_accu), .lm_delta_time_idx(a_idx),
        .lm_delta_time_max(a_max), .lm_delta_time_min(a_min), .lm_delta_done_sync(a_done),
        .lm_delta_adj_factor(a_adj), .lm_err_cnt(a_err)
    );

    always #5 axi_aclk = ~axi_aclk;

    logic [15:0] m_timer = '0;
    always @(posedge axi_aclk) m_timer <= axi_aresetn ? m_timer + 16'd1 : 16'd0;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] pend_q [$];
    time_pair_t  pair_q [$];
    int unsigned m_err = 0;
    logic        last_pop = 1'b0;

    typedef struct {
        logic [15:0] tx_at;
        logic [15:0] rx_at;
        logic [15:0] exp_delta;
    } vec_t;
    vec_t vecs [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; the model mirrors queue behaviour at the same edge.
    task automatic step(input logic tx, input logic rx, input logic pop, input logic clr);
        time_pair_t exp_p;
        time_pair_t p;
        exp_p = '0;
        tx_evt = tx; rx_evt = rx; lm_pop = pop; lm_clear = clr;
        if (clr) begin
            pend_q.delete();
            pair_q.delete();
            m_err = 0;
        end else begin
            if (pop && pair_q.size() > 0) exp_p = pair_q.pop_front();
            if (lm_go && rx) begin
                if (pend_q.size() > 0) begin
                    p.snd = pend_q.pop_front();
                    p.rcv = m_timer;
                    if (pair_q.size() < RD) pair_q.push_back(p);
                end else begin
                    m_err++;
                end
            end
            if (lm_go && tx) begin
                if (pend_q.size() < PD) pend_q.push_back(m_timer);
                else m_err++;
            end
        end
        @(negedge axi_aclk);
        tx_evt = 1'b0; rx_evt = 1'b0; lm_pop = 1'b0; lm_clear = 1'b0;
        if (pop) begin
            chk("pop_rdy", 64'(lm_time_rdy), 64'd1);
            chk("pop_snd", 64'(lm_snd_time), 64'(exp_p.snd));
            chk("pop_rcv", 64'(lm_rcv_time), 64'(exp_p.rcv));
        end else if (last_pop) begin
            chk("rdy_pulse_end", 64'(lm_time_rdy), 64'd0);
        end
        last_pop = pop;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_until(input logic [15:0] t);
        int unsigned n;
        n = 0;
        while (m_timer != t && n < 70000) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (m_timer != t) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_timer: got %0h expected %0h", m_timer, t);
        end
    endtask

    task automatic check_reset();
        chk("rst_datav", 64'(lm_datav), 64'd0);
        chk("rst_full", 64'(lm_full), 64'd0);
        chk("rst_rdy", 64'(lm_time_rdy), 64'd0);
        chk("rst_snd", 64'(lm_snd_time), 64'd0);
        chk("rst_rcv", 64'(lm_rcv_time), 64'd0);
        chk("rst_accu", 64'(lm_delta_time_accu), 64'd0);
        chk("rst_idx", 64'(lm_delta_time_idx), 64'd0);
        chk("rst_max", 64'(lm_delta_time_max), 64'd0);
        chk("rst_min", 64'(lm_delta_time_min), 64'hFFFF);
        chk("rst_done", 64'(lm_delta_done_sync), 64'd0);
        chk("rst_err", 64'(lm_err_cnt), 64'd0);
        chk("rst_adj", 64'(lm_delta_adj_factor), 64'd0);
        chk("rst_adj_b", 64'(a_adj), 64'h30);
    endtask

    initial begin
        vecs[0] = '{tx_at: 16'd100, rx_at: 16'd150, exp_delta: 16'd50};
        vecs[1] = '{tx_at: 16'd200, rx_at: 16'd250, exp_delta: 16'd50};
        vecs[2] = '{tx_at: 16'd300, rx_at: 16'd350, exp_delta: 16'd50};

        repeat (3) @(negedge axi_aclk);
        check_reset();
        axi_aresetn = 1'b1;
        lm_go = 1'b1;
        lm_lat_pkt_cnt = 32'd3;

        // Basic pairing and statistics with a three-pair measurement.
        for (int i = 0; i < 3; i++) begin
            wait_until(vecs[i].tx_at);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            wait_until(vecs[i].rx_at);
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
        idle(LM_PIPE_DEPTH + 3);
        chk("t1_datav", 64'(lm_datav), 64'd3);
        chk("t1_accu", 64'(lm_delta_time_accu), 64'd150);
        chk("t1_idx", 64'(lm_delta_time_idx), 64'd3);
        chk("t1_max", 64'(lm_delta_time_max), 64'd50);
        chk("t1_min", 64'(lm_delta_time_min), 64'd50);
        chk("t1_done", 64'(lm_delta_done_sync), 64'd1);
        chk("t1_adj_accu", 64'(a_accu), 64'd6);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            chk("t1_delta", 64'(lm_rcv_time - lm_snd_time), 64'(vecs[i].exp_delta));
        end
        chk("t1_datav_drained", 64'(lm_datav), 64'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(LM_PIPE_DEPTH + 3);
        chk("t1_frozen_idx", 64'(lm_delta_time_idx), 64'd3);
        chk("t1_frozen_accu", 64'(lm_delta_time_accu), 64'd150);
        chk("t1_post_done_datav", 64'(lm_datav), 64'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_done", 64'(lm_delta_done_sync), 64'd0);
        chk("clr_idx", 64'(lm_delta_time_idx), 64'd0);
        chk("clr_min", 64'(lm_delta_time_min), 64'hFFFF);
        lm_lat_pkt_cnt = 32'd0;

        // Pending-queue overflow and orphan rx.
        repeat (17) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_err_drop", 64'(lm_err_cnt), 64'd1);
        repeat (16) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_err_orphan", 64'(lm_err_cnt), 64'd2);
        idle(LM_PIPE_DEPTH + 3);
        chk("t3_datav", 64'(lm_datav), 64'd16);
        chk("t3_idx", 64'(lm_delta_time_idx), 64'd16);
        chk("t3_max", 64'(lm_delta_time_max), 64'd17);
        chk("t3_min", 64'(lm_delta_time_min), 64'd17);
        repeat (16) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Same-cycle tx+rx on a full pending queue; pair write coinciding with pop.
        repeat (16) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_err_same", 64'(lm_err_cnt), 64'd2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_still_full", 64'(lm_err_cnt), 64'd3);
        idle(4);
        chk("t5_datav_a", 64'(lm_datav), 64'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_datav_pushpop", 64'(lm_datav), 64'd1);
        chk("t5_err_model", 64'(lm_err_cnt), 64'(m_err));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_clr_err", 64'(lm_err_cnt), 64'd0);

        // Fill the pair FIFO to capacity and one beyond.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4095) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("t4_full", 64'(lm_full), 64'd1);
        chk("t4_datav", 64'(lm_datav), 64'd4096);
        chk("t4_idx", 64'(lm_delta_time_idx), 64'd4096);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("t4_datav_hold", 64'(lm_datav), 64'd4096);
        chk("t4_idx_over", 64'(lm_delta_time_idx), 64'd4097);
        chk("t4_accu", 64'(lm_delta_time_accu), 64'd4097);
        chk("t4_max", 64'(lm_delta_time_max), 64'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_unfull", 64'(lm_full), 64'd0);
        chk("t4_datav_pop", 64'(lm_datav), 64'd4095);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_empty_pop_datav", 64'(lm_datav), 64'd0);

        // Timer wrap, and clamping on the calibrated instance.
        wait_until(16'hFFF0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        wait_until(16'h0010);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(LM_PIPE_DEPTH + 3);
        chk("t2_max", 64'(lm_delta_time_max), 64'h20);
        chk("t2_accu", 64'(lm_delta_time_accu), 64'h20);
        chk("t2_adj_max", 64'(a_max), 64'd0);
        chk("t2_adj_min", 64'(a_min), 64'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Events ignored while lm_go is low.
        lm_go = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("go_err", 64'(lm_err_cnt), 64'd0);
        chk("go_idx", 64'(lm_delta_time_idx), 64'd1);
        lm_go = 1'b1;

        // Clear with an rx and a pop in the same cycle, pair in flight.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle(4);
        chk("t6_datav", 64'(lm_datav), 64'd0);
        chk("t6_idx", 64'(lm_delta_time_idx), 64'd0);
        chk("t6_min", 64'(lm_delta_time_min), 64'hFFFF);
        chk("t6_done", 64'(lm_delta_done_sync), 64'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_pend_flushed", 64'(lm_err_cnt), 64'd1);

        // Reset with a pair in the pipeline.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        axi_aresetn = 1'b0;
        pend_q.delete();
        pair_q.delete();
        m_err = 0;
        repeat (2) @(negedge axi_aclk);
        check_reset();
        axi_aresetn = 1'b1;
        idle(4);
        chk("post_rst_datav", 64'(lm_datav), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
